// File: rtl/mult_div_unit.sv
`timescale 1ns/1ps
// mult_div_unit: iterative signed multiply / divide producing MIPS-style HI/LO results.
// Latency: start sampled at edge t0, hi/lo written at edge t0+WIDTH+1, done pulses the following cycle.
// Backpressure: none; start is sampled only in IDLE and ignored while busy.
//
// Ports:
//   clk, reset        : rising-edge clock, asynchronous active-high reset
//   start, op, a, b   : request (op 0 = mult, 1 = div) with two's-complement operands
//   busy, done        : busy while state != IDLE; done is a one-cycle completion pulse
//   hi, lo            : mult -> product upper/lower half; div -> remainder/quotient
//   div_zero          : divide-by-zero flag, coincident with done
//
// Optional feature macro MULT_DIV_DIVZERO_EXC_EN:
//   defined   -> divide by zero leaves hi/lo untouched and raises div_zero with done
//   undefined -> div_zero tied 0; divide by zero writes hi = a, lo = all ones
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int            CW      = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_END = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic               op_q;      // latched operation
  logic               neg_q;     // product / quotient must be negated
  logic               sign_a_q;  // remainder takes the sign of a
  logic               dz_q;      // divide by zero detected at start
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  // mult: {partial product high half, multiplier being shifted out}
  // div : {partial remainder, dividend bits being shifted in / quotient bits shifted out}
  logic [2*WIDTH-1:0] acc;

  // Magnitude as an unsigned value; the most-negative input maps to 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  // One iteration of either algorithm.
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH-1:0]   div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] acc_step;

  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? mag_a : {WIDTH{1'b0}})};
    // Remainder shifted left with the next dividend bit appended.
    div_shift = acc[2*WIDTH-1:WIDTH-1];
    div_ge    = (div_shift >= {1'b0, mag_b});
    // When the trial subtraction succeeds the result is below mag_b, so WIDTH bits suffice.
    div_diff  = div_shift[WIDTH-1:0] - mag_b;
    if (op_q) begin
      if (div_ge) acc_step = {div_diff, acc[WIDTH-2:0], 1'b1};
      else        acc_step = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end else begin
      acc_step = {mul_sum, acc[WIDTH-1:1]};
    end
  end

  // Sign correction applied in FIX.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_raw;
  logic [WIDTH-1:0]   rem_raw;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  always_comb begin
    prod_fix = neg_q ? -acc : acc;
    quo_raw  = acc[WIDTH-1:0];
    rem_raw  = acc[2*WIDTH-1:WIDTH];
    quo_fix  = neg_q ? -quo_raw : quo_raw;
    rem_fix  = sign_a_q ? -rem_raw : rem_raw;
  end

`ifndef MULT_DIV_DIVZERO_EXC_EN
  // Original dividend rebuilt from sign and magnitude (MIN wraps back to MIN).
  logic [WIDTH-1:0] a_orig;
  assign a_orig   = sign_a_q ? -mag_a : mag_a;
  assign div_zero = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      op_q     <= 1'b0;
      neg_q    <= 1'b0;
      sign_a_q <= 1'b0;
      dz_q     <= 1'b0;
      mag_a    <= '0;
      mag_b    <= '0;
      acc      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
`ifdef MULT_DIV_DIVZERO_EXC_EN
      div_zero <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_q     <= op;
            neg_q    <= a[WIDTH-1] ^ b[WIDTH-1];
            sign_a_q <= a[WIDTH-1];
            dz_q     <= op && (b == '0);
            mag_a    <= magnitude(a);
            mag_b    <= magnitude(b);
            // mult shifts the multiplier out of the low half; div shifts the dividend out.
            acc      <= {{WIDTH{1'b0}}, (op ? magnitude(a) : magnitude(b))};
            cnt      <= '0;
            busy     <= 1'b1;
            state    <= CALC;
          end
        end
        CALC: begin
          acc <= acc_step;
          cnt <= cnt + CNT_ONE;
          if (cnt == CNT_END) state <= FIX;
        end
        FIX: begin
          done  <= 1'b1;
          state <= DONE;
`ifdef MULT_DIV_DIVZERO_EXC_EN
          if (!op_q) begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end else if (!dz_q) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end
          div_zero <= dz_q;
`else
          if (!op_q) begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end else if (dz_q) begin
            hi <= a_orig;
            lo <= '1;
          end else begin
            hi <= rem_fix;
            lo <= quo_fix;
          end
`endif
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
`ifdef MULT_DIV_DIVZERO_EXC_EN
          div_zero <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
`timescale 1ns/1ps
module tb_mult_div_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         op = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         div_zero;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: done=1 with no outstanding request (t=%0t)", $time);
      end else begin
        e = sb_q.pop_front();
        chk("res_hi", 64'(hi), 64'(e.hi));
        chk("res_lo", 64'(lo), 64'(e.lo));
        chk("res_div_zero", 64'(div_zero), 64'(e.dz));
        chk("busy_at_done", 64'(busy), 64'd1);
      end
    end else begin
      // div_zero may only be raised alongside done
      chk("div_zero_idle", 64'(div_zero), 64'd0);
    end
  end

  // Issue one operation, then check latency and busy duration.
  task automatic run_op(input logic o, input logic [W-1:0] aa, input logic [W-1:0] bb,
                        input logic [W-1:0] eh, input logic [W-1:0] el, input logic ez);
    int n;
    int bc;
    sb_q.push_back('{hi: eh, lo: el, dz: ez});
    @(negedge clk);
    op = o; a = aa; b = bb; start = 1'b1;
    @(negedge clk);               // cycle 1 after the start edge
    start = 1'b0;
    a = $urandom; b = $urandom; op = ~o;   // must not disturb the latched operation
    n = 1;
    bc = 0;
    while (done !== 1'b1 && n < 200) begin
      if (busy === 1'b1) bc++;
      @(negedge clk);
      n++;
    end
    if (busy === 1'b1) bc++;
    chk("done_latency", 64'(n), 64'(W + 2));
    chk("busy_cycles", 64'(bc), 64'(W + 2));
    @(negedge clk);
    chk("idle_after_done", 64'(busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int dones;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_div_zero", 64'(div_zero), 64'd0);
    reset = 1'b0;

    // Multiplications
    run_op(1'b0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    run_op(1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0);
    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0);
    run_op(1'b0, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, 1'b0);

    // Divisions
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
    run_op(1'b1, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0);
    run_op(1'b1, 32'd7,         32'hFFFF_FF9C, 32'd7,         32'd0,         1'b0);

    // Preload hi/lo = 1234/5678, then divide by zero
    run_op(1'b1, 32'h5678_1234, 32'h0001_0000, 32'h0000_1234, 32'h0000_5678, 1'b0);
`ifdef MULT_DIV_DIVZERO_EXC_EN
    run_op(1'b1, 32'd5, 32'd0, 32'h0000_1234, 32'h0000_5678, 1'b1);
`else
    run_op(1'b1, 32'd5, 32'd0, 32'h0000_0005, 32'hFFFF_FFFF, 1'b0);
`endif

    // start re-pulsed while busy must be ignored
    sb_q.push_back('{hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFEB, dz: 1'b0});
    @(negedge clk);
    op = 1'b0; a = 32'd7; b = 32'hFFFF_FFFD; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    for (int n = 1; n <= 40; n++) begin
      if (done === 1'b1) dones++;
      if (n == 3 || n == 20) begin
        start = 1'b1; op = 1'b1; a = 32'd9; b = 32'd4;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("repulse_done_count", 64'(dones), 64'd1);
    chk("repulse_idle", 64'(busy), 64'd0);

    // Asynchronous reset in the middle of a divide
    @(negedge clk);
    op = 1'b1; a = 32'd100; b = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);    // cycle 10 of the operation
    chk("busy_before_reset", 64'(busy), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    chk("arst_hi", 64'(hi), 64'd0);
    chk("arst_lo", 64'(lo), 64'd0);
    dones = 0;
    repeat (3) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    reset = 1'b0;
    repeat (W + 4) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    chk("arst_no_done", 64'(dones), 64'd0);

    // Operation after reset completes normally
    run_op(1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Parametrised multicycle signed multiply/divide unit for the multicycle CPU datapath.
- Produces MIPS-style HI/LO results for mult/div.
- Control FSM pulses `start` and waits for `done`; HI/LO are then copied into the HI/LO registers.
- Generalises the fixed-width single-cycle ALU path to a WIDTH-configurable iterative engine with a start/done handshake.

Parameters:
- WIDTH, 32, operand width in bits; HI and LO are each WIDTH bits; WIDTH >= 4.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- op  input  1  0 = mult, 1 = div
- a  input  WIDTH  multiplicand / dividend (two's complement)
- b  input  WIDTH  multiplier / divisor (two's complement)
- busy  output  1  high whenever state != IDLE
- done  output  1  one-cycle completion pulse
- hi  output  WIDTH  mult: upper product half; div: remainder
- lo  output  WIDTH  mult: lower product half; div: quotient
- div_zero  output  1  divide-by-zero flag (see Optional Feature)

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: state=IDLE; busy, done, div_zero = 0; hi = lo = 0; internal accumulators = 0.
- States:
  - IDLE: start=1 latches a, b, op; stores operand magnitudes and result sign; clears the iteration counter; goes to CALC. start=0: stays in IDLE.
  - CALC: exactly WIDTH cycles, one iteration each.
    - mult: unsigned shift-add on magnitudes into a 2*WIDTH accumulator.
    - div: unsigned restoring step on magnitudes (shift remainder, trial subtract, set quotient bit).
    - After the WIDTH-th iteration (counter == WIDTH-1): go to FIX.
  - FIX: apply sign correction; write hi/lo; go to DONE.
    - mult: product negated iff sign(a) != sign(b).
    - div: quotient negated iff signs differ; remainder takes sign of a.
  - DONE: done=1 for this single cycle; next edge returns to IDLE.
- Latency: if start is sampled at edge t0, hi/lo update at edge t0+WIDTH+1 and done is high in the cycle following that edge. Total is WIDTH+2 edges.
- busy is high from edge t0 through the DONE cycle inclusive. start while busy is ignored; the operation in flight is unaffected.
- a, b, op may change after t0 without effect.
- hi/lo hold their last result until the next FIX write; they are not cleared by start.
- Arithmetic:
  - Magnitude of the most-negative value is taken as unsigned 2^(WIDTH-1).
  - Division truncates toward zero.
  - MIN / -1 yields lo = MIN, hi = 0 (natural wrap, no flag).
  - mult MIN * MIN yields hi = 2^(WIDTH-2), lo = 0.
- Divide by zero: detected in IDLE when op=1 and b=0. CALC still runs its full WIDTH cycles, so latency is identical; the result is per Optional Feature.
- Reset mid-operation: immediate return to IDLE with reset values; no done pulse is produced.

Optional Feature:
- Macro: MULT_DIV_DIVZERO_EXC_EN
- Defined:
  - Divide by zero leaves hi/lo unchanged (FIX writes nothing).
  - div_zero=1 in the same cycle as done; 0 otherwise.
  - Control FSM treats this as an exception.
- Undefined:
  - div_zero is tied 0.
  - Divide by zero writes hi = a and lo = all ones; done as normal.

Test Plan (WIDTH=32):
- mult a=7, b=-3 (FFFFFFFD) -> hi=FFFFFFFF, lo=FFFFFFEB; done exactly 34 edges after start edge; busy high 34 cycles.
- mult a=80000000, b=80000000 -> hi=40000000, lo=00000000. mult a=FFFFFFFF, b=FFFFFFFF -> hi=0, lo=1.
- div a=-7, b=2 -> lo=FFFFFFFD (-3), hi=FFFFFFFF (-1). div a=80000000, b=FFFFFFFF -> lo=80000000, hi=0.
- div a=5, b=0 with hi/lo preloaded 1234/5678:
  - Macro on -> hi/lo unchanged; div_zero=1 coincident with done.
  - Macro off -> hi=5, lo=FFFFFFFF; div_zero=0.
- start re-pulsed with new operands at cycles 3 and 20 of a mult 7*-3 -> result still FFFFFFFF/FFFFFFEB; a single done pulse.
- reset asserted asynchronously at cycle 10 of a div -> busy, done, hi, lo = 0 immediately; no done pulse; a subsequent op completes correctly.
